// File: rtl/wb_trace_monitor.sv
// Write-back trace monitor: logs each WriteData change with its PC in a FWFT FIFO,
// tracks the minimum written value and freezes all statistics once the PC stalls.
module wb_trace_monitor #(
    parameter int DEPTH       = 8,
    parameter int HALT_CYCLES = 4,
    parameter int CW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   WriteData,
    input  logic [31:0]   ProgramCounter,
    input  logic          rd_en,
    output logic [31:0]   rd_data,
    output logic [31:0]   rd_pc,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          min_valid,
    output logic [31:0]   min_value,
    output logic [31:0]   min_pc,
    output logic [CW-1:0] cycle_count,
    output logic [CW-1:0] change_count,
    output logic          halted,
    output logic [31:0]   halt_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(HALT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t        state_q, state_d;
    logic [31:0]   wd_prev, pc_prev;
    logic [SW-1:0] stable_cnt;
    logic [31:0]   wd_mem [DEPTH];
    logic [31:0]   pc_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic run, change, pop, push_ok, min_upd, pc_eq, halt_hit;

    assign run      = (state_q == RUN);
    assign change   = run && (WriteData != wd_prev);
    assign pc_eq    = (ProgramCounter == pc_prev);
    assign halt_hit = run && pc_eq && (stable_cnt == SW'(HALT_CYCLES - 1));
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign pop      = rd_en && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok  = change && (!full || pop);
    assign min_upd  = change && (!min_valid || (WriteData < min_value));
    assign halted   = (state_q == HALTED);
    assign rd_data  = empty ? 32'd0 : wd_mem[rd_ptr];
    assign rd_pc    = empty ? 32'd0 : pc_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (halt_hit) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_prev      <= '0;
            pc_prev      <= '0;
            stable_cnt   <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            min_valid    <= 1'b0;
            min_value    <= 32'hFFFF_FFFF;
            min_pc       <= '0;
            cycle_count  <= '0;
            change_count <= '0;
            halt_pc      <= '0;
        end else begin
            if (state_q == IDLE || run) begin
                wd_prev <= WriteData;
                pc_prev <= ProgramCounter;
            end
            if (run) begin
                if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
                stable_cnt <= pc_eq ? stable_cnt + 1'b1 : '0;
                if (change && change_count != '1) change_count <= change_count + 1'b1;
                if (change && full && !pop) overflow <= 1'b1;
                if (min_upd) begin
                    min_value <= WriteData;
                    min_pc    <= ProgramCounter;
                    min_valid <= 1'b1;
                end
                if (halt_hit) halt_pc <= ProgramCounter;
            end
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (pop && !push_ok) count <= count - 1'b1;
        end
    end

    // Storage carries no reset; rd_data/rd_pc are masked while empty.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            wd_mem[wr_ptr] <= WriteData;
            pc_mem[wr_ptr] <= ProgramCounter;
        end
    end

endmodule

// File: tb/tb_wb_trace_monitor.sv
// Directed bench for wb_trace_monitor: FIFO heads are checked against an expected
// queue by a negedge monitor, status outputs by direct checks after each step.
module tb_wb_trace_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_s = 1'b1;
    logic [31:0] WriteData = '0;
    logic [31:0] ProgramCounter = '0;
    logic        rd_en = 1'b0;

    logic [31:0] rd_data, rd_pc, min_value, min_pc, halt_pc;
    logic        empty, full, overflow, min_valid, halted;
    logic [15:0] cycle_count, change_count;

    logic [31:0] s_rd_data, s_rd_pc, s_min_value, s_min_pc, s_halt_pc;
    logic        s_empty, s_full, s_overflow, s_min_valid, s_halted;
    logic [3:0]  s_cycle_count, s_change_count;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [63:0] exp_q[$];

    logic [31:0] t1_wd [5] = '{32'd5, 32'd9, 32'd3, 32'd3, 32'd7};
    logic [31:0] t1_pc [5] = '{32'd4, 32'd8, 32'd12, 32'd16, 32'd20};

    always #5 clk = ~clk;

    wb_trace_monitor #(.DEPTH(8), .HALT_CYCLES(4), .CW(16)) dut (
        .clk(clk), .rst(rst), .WriteData(WriteData), .ProgramCounter(ProgramCounter),
        .rd_en(rd_en), .rd_data(rd_data), .rd_pc(rd_pc), .empty(empty), .full(full),
        .overflow(overflow), .min_valid(min_valid), .min_value(min_value), .min_pc(min_pc),
        .cycle_count(cycle_count), .change_count(change_count), .halted(halted),
        .halt_pc(halt_pc)
    );

    wb_trace_monitor #(.DEPTH(8), .HALT_CYCLES(4), .CW(4)) u_sat (
        .clk(clk), .rst(rst_s), .WriteData(WriteData), .ProgramCounter(ProgramCounter),
        .rd_en(1'b0), .rd_data(s_rd_data), .rd_pc(s_rd_pc), .empty(s_empty), .full(s_full),
        .overflow(s_overflow), .min_valid(s_min_valid), .min_value(s_min_value),
        .min_pc(s_min_pc), .cycle_count(s_cycle_count), .change_count(s_change_count),
        .halted(s_halted), .halt_pc(s_halt_pc)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] wd, input logic [31:0] pc);
        WriteData      = wd;
        ProgramCounter = pc;
        tick();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_empty"}, 64'(empty), 64'd1);
        check({tag, "_full"}, 64'(full), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
        check({tag, "_min_valid"}, 64'(min_valid), 64'd0);
        check({tag, "_min_value"}, 64'(min_value), 64'hFFFF_FFFF);
        check({tag, "_min_pc"}, 64'(min_pc), 64'd0);
        check({tag, "_cycle_count"}, 64'(cycle_count), 64'd0);
        check({tag, "_change_count"}, 64'(change_count), 64'd0);
        check({tag, "_halted"}, 64'(halted), 64'd0);
        check({tag, "_halt_pc"}, 64'(halt_pc), 64'd0);
        check({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    endtask

    // Monitor: every cycle that will pop the head, compare it with the queue front.
    always @(negedge clk) begin
        if (!rst && rd_en && !empty) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL fifo_head: got %0h@%0h expected nothing queued", rd_data, rd_pc);
            end else begin
                check("fifo_head", {rd_data, rd_pc}, exp_q.pop_front());
            end
        end
    end

    initial begin
        tick();
        tick();
        check_reset_state("reset");

        // Test 1: change events and minimum tracking
        rst = 1'b0;
        drive(32'd5, 32'd0);
        check("t1_idle_cycle_count", 64'(cycle_count), 64'd0);
        for (int i = 0; i < 5; i++) drive(t1_wd[i], t1_pc[i]);
        exp_q.push_back({32'd9, 32'd8});
        exp_q.push_back({32'd3, 32'd12});
        exp_q.push_back({32'd7, 32'd20});
        check("t1_change_count", 64'(change_count), 64'd3);
        check("t1_min_value", 64'(min_value), 64'd3);
        check("t1_min_pc", 64'(min_pc), 64'd12);
        check("t1_min_valid", 64'(min_valid), 64'd1);
        check("t1_empty", 64'(empty), 64'd0);
        check("t1_cycle_count", 64'(cycle_count), 64'd5);

        // Test 2: PC stuck at 0x40 halts after 4 equal compares
        for (int i = 0; i < 4; i++) drive(32'd7, 32'h40);
        check("t2_not_yet_halted", 64'(halted), 64'd0);
        drive(32'd7, 32'h40);
        check("t2_halted", 64'(halted), 64'd1);
        check("t2_halt_pc", 64'(halt_pc), 64'h40);
        check("t2_cycle_frozen_at", 64'(cycle_count), 64'd10);
        drive(32'd1, 32'h40);
        drive(32'd2, 32'h44);
        check("t2_change_frozen", 64'(change_count), 64'd3);
        check("t2_min_frozen", 64'(min_value), 64'd3);
        check("t2_cycle_frozen", 64'(cycle_count), 64'd10);
        check("t2_still_halted", 64'(halted), 64'd1);
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rd_en = 1'b0;
        check("t2_drained_empty", 64'(empty), 64'd1);

        // Test 4: reads on an empty FIFO have no effect
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_empty", 64'(empty), 64'd1);
            check("t4_rd_data", 64'({rd_data, rd_pc}), 64'd0);
            check("t4_no_flags", 64'({full, overflow}), 64'd0);
        end
        rd_en = 1'b0;

        // Test 3: overflow with DEPTH=8, then pop+push while full
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(32'd0, 32'd0);
        for (int i = 1; i <= 10; i++) begin
            drive(32'(i), 32'(4 * i));
            if (i <= 8) exp_q.push_back({32'(i), 32'(4 * i)});
            if (i == 8) begin
                check("t3_full_at_8", 64'(full), 64'd1);
                check("t3_no_overflow_at_8", 64'(overflow), 64'd0);
            end
        end
        check("t3_full", 64'(full), 64'd1);
        check("t3_overflow", 64'(overflow), 64'd1);
        check("t3_change_count", 64'(change_count), 64'd10);
        check("t3_min", 64'({min_value, min_pc}), {32'd1, 32'd4});
        rd_en = 1'b1;
        drive(32'd11, 32'd44);
        exp_q.push_back({32'd11, 32'd44});
        rd_en = 1'b0;
        check("t3_full_after_pop_push", 64'(full), 64'd1);
        check("t3_overflow_sticky", 64'(overflow), 64'd1);
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        rd_en = 1'b0;
        check("t3_drained_empty", 64'(empty), 64'd1);
        check("t3_drained_not_full", 64'(full), 64'd0);

        // Test 5: reset mid-run discards four pushes
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(32'd0, 32'd0);
        for (int i = 1; i <= 4; i++) drive(32'(i), 32'(4 * i));
        check("t5_pre_reset_changes", 64'(change_count), 64'd4);
        rst = 1'b1;
        tick();
        check_reset_state("t5_reset");
        rst = 1'b0;
        drive(32'd100, 32'd100);
        check("t5_idle_cycle_count", 64'(cycle_count), 64'd0);
        check("t5_idle_change_count", 64'(change_count), 64'd0);
        drive(32'd101, 32'd104);
        exp_q.push_back({32'd101, 32'd104});
        check("t5_cycle_count", 64'(cycle_count), 64'd1);
        check("t5_change_count", 64'(change_count), 64'd1);
        check("t5_min", 64'({min_value, min_pc}), {32'd101, 32'd104});
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t5_empty", 64'(empty), 64'd1);

        // Test 6: CW=4 cycle counter saturates at 15
        rst_s = 1'b0;
        drive(32'd101, 32'h1000);
        check("t6_idle", 64'(s_cycle_count), 64'd0);
        for (int i = 1; i <= 10; i++) drive(32'd101, 32'h1000 + 32'(4 * i));
        check("t6_count_10", 64'(s_cycle_count), 64'd10);
        for (int i = 11; i <= 20; i++) drive(32'd101, 32'h1000 + 32'(4 * i));
        check("t6_saturated", 64'(s_cycle_count), 64'd15);
        check("t6_not_halted", 64'(s_halted), 64'd0);

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
